// File: rtl/audio_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pwm_pkg
// Brief    : Shared PWM constants and state encoding for audio_pwm_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package audio_pwm_pkg;

    localparam int W_PWM      = 8;
    localparam int PWM_PERIOD = 256;

    localparam logic [W_PWM-1:0] c_MIDSCALE = 8'h80;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_fifo
// Brief    : Synchronous sample-pair FIFO; rdata shows the head entry so it is
//            valid in the same cycle as pop. Pop on empty / push on full ignored.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int W_LEVEL = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [W_LEVEL-1:0] level
);

    localparam int W_PTR = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [W_PTR-1:0]   r_wr_ptr;
    logic [W_PTR-1:0]   r_rd_ptr;
    logic [W_LEVEL-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == W_LEVEL'(DEPTH));
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : audio_pwm_ctrl
// Brief    : Stereo sample sequencer and dual 8-bit PWM generator. Optional
//            refill interrupt built when AUDIO_PWM_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module audio_pwm_ctrl
    import audio_pwm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int W_LEVEL    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic [7:0]         cfg_repeat,
    input  logic [W_LEVEL-1:0] cfg_irq_thresh,
    input  logic               wr_vld,
    output logic               wr_rdy,
    input  logic [15:0]        wr_data,
    input  logic               underflow_clr,
    output logic               underflow,
    output logic [W_LEVEL-1:0] fifo_level,
    output logic               irq,
    output logic               audio_l,
    output logic               audio_r
);

    localparam logic [W_PWM-1:0] c_CTR_MAX = W_PWM'(PWM_PERIOD - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W_PWM-1:0]   r_ctr;
    logic [W_PWM-1:0]   w_ctr_next;
    logic [7:0]         r_rep;
    logic [7:0]         w_rep_next;
    logic               w_pop_due;
    logic               w_pop_ok;
    logic [W_PWM-1:0]   r_cur_l;
    logic [W_PWM-1:0]   r_cur_r;
    logic               r_underflow;
    logic               r_audio_l;
    logic               r_audio_r;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [15:0]        w_fifo_rdata;
    logic [W_LEVEL-1:0] w_fifo_level;
    logic               w_push;
    logic               w_run;

    // Ready comes from registered occupancy only: a same-cycle pop cannot free a slot.
    assign wr_rdy     = !w_fifo_full;
    assign w_push     = wr_vld && wr_rdy;
    assign w_pop_ok   = w_pop_due && !w_fifo_empty;
    assign fifo_level = w_fifo_level;
    assign underflow  = r_underflow;
    assign audio_l    = r_audio_l;
    assign audio_r    = r_audio_r;
    assign w_run      = (r_state == RUN) && cfg_en;

    audio_sample_fifo #(
        .WIDTH   (16),
        .DEPTH   (FIFO_DEPTH),
        .W_LEVEL (W_LEVEL)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (wr_data),
        .pop   (w_pop_due),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_rep   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctr   <= w_ctr_next;
            r_rep   <= w_rep_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctr_next   = r_ctr;
        w_rep_next   = r_rep;
        w_pop_due    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ctr_next = '0;
                w_rep_next = '0;
                if (cfg_en) begin
                    w_state_next = RUN;
                    w_pop_due    = 1'b1;
                end
            end
            RUN: begin
                if (!cfg_en) begin
                    w_state_next = IDLE;
                    w_ctr_next   = '0;
                    w_rep_next   = '0;
                end else begin
                    w_ctr_next = r_ctr + 1'b1;
                    if (r_ctr == c_CTR_MAX) begin
                        if (r_rep == cfg_repeat) begin
                            w_rep_next = '0;
                            w_pop_due  = 1'b1;
                        end else begin
                            w_rep_next = r_rep + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A due pop on an empty FIFO keeps the previous samples playing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_l     <= c_MIDSCALE;
            r_cur_r     <= c_MIDSCALE;
            r_underflow <= 1'b0;
            r_audio_l   <= 1'b0;
            r_audio_r   <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_cur_l <= w_fifo_rdata[7:0];
                r_cur_r <= w_fifo_rdata[15:8];
            end
            if (w_pop_due && w_fifo_empty) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
            r_audio_l <= w_run && (r_ctr < r_cur_l);
            r_audio_r <= w_run && (r_ctr < r_cur_r);
        end
    end

`ifdef AUDIO_PWM_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= cfg_en && (w_fifo_level <= cfg_irq_thresh);
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_thresh;

    assign w_unused_irq_thresh = ^cfg_irq_thresh;
    assign irq                 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_pwm_ctrl
// Brief    : Directed self-checking bench for audio_pwm_ctrl (FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_pwm_ctrl;

`ifdef AUDIO_PWM_IRQ_EN
    localparam int IRQ_ON = 1;
`else
    localparam int IRQ_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic [7:0]  cfg_repeat;
    logic [2:0]  cfg_irq_thresh;
    logic        wr_vld;
    logic        wr_rdy;
    logic [15:0] wr_data;
    logic        underflow_clr;
    logic        underflow;
    logic [2:0]  fifo_level;
    logic        irq;
    logic        audio_l;
    logic        audio_r;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_l;
    int cnt_r;
    int acc;
    int exp_l [7] = '{10, 10, 20, 20, 30, 30, 30};

    audio_pwm_ctrl #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_en         (cfg_en),
        .cfg_repeat     (cfg_repeat),
        .cfg_irq_thresh (cfg_irq_thresh),
        .wr_vld         (wr_vld),
        .wr_rdy         (wr_rdy),
        .wr_data        (wr_data),
        .underflow_clr  (underflow_clr),
        .underflow      (underflow),
        .fifo_level     (fifo_level),
        .irq            (irq),
        .audio_l        (audio_l),
        .audio_r        (audio_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        wr_vld  = 1'b1;
        wr_data = d;
        tick();
        wr_vld  = 1'b0;
    endtask

    task automatic run_window();
        cnt_l = 0;
        cnt_r = 0;
        repeat (256) begin
            tick();
            cnt_l += int'(audio_l);
            cnt_r += int'(audio_r);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        cfg_en         = 1'b0;
        cfg_repeat     = 8'd0;
        cfg_irq_thresh = 3'd0;
        wr_vld         = 1'b0;
        wr_data        = 16'h0000;
        underflow_clr  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_wr_rdy", wr_rdy, 1);
        check("rst_level", fifo_level, 0);
        check("rst_underflow", underflow, 0);
        check("rst_irq", irq, 0);
        check("rst_audio_l", audio_l, 0);
        check("rst_audio_r", audio_r, 0);

        // Backpressure: 5 pushes into a 4-deep FIFO while idle
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            wr_vld  = 1'b1;
            wr_data = 16'hC040;
            if (wr_rdy) acc++;
            tick();
        end
        wr_vld = 1'b0;
        check("bp_accepted", acc, 4);
        check("bp_wr_rdy", wr_rdy, 0);
        check("bp_level", fifo_level, 4);

        // Start pop, then one full PWM period
        cfg_repeat = 8'd0;
        cfg_en     = 1'b1;
        tick();
        check("start_wr_rdy", wr_rdy, 1);
        check("start_level", fifo_level, 3);
        check("start_audio_l", audio_l, 0);
        run_window();
        check("pwm_duty_l", cnt_l, 64);
        check("pwm_duty_r", cnt_r, 192);
        check("boundary_level", fifo_level, 2);

        // Mid-run disable at ctr=100
        repeat (100) tick();
        check("pre_dis_audio_r", audio_r, 1);
        cfg_en = 1'b0;
        tick();
        check("dis_audio_l", audio_l, 0);
        check("dis_audio_r", audio_r, 0);
        check("dis_level", fifo_level, 2);

        // Reset during RUN
        cfg_en = 1'b1;
        tick();
        repeat (10) tick();
        check("run2_level", fifo_level, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_wr_rdy", wr_rdy, 1);
        check("mid_rst_audio_l", audio_l, 0);
        check("mid_rst_audio_r", audio_r, 0);
        cfg_en = 1'b0;
        rst_n  = 1'b1;
        tick();

        // Sequencing with cfg_repeat=1: 10, 20, 30 then underflow
        cfg_repeat = 8'd1;
        push(16'hFF0A);
        push(16'hFF14);
        push(16'hFF1E);
        check("seq_prefill_level", fifo_level, 3);
        cfg_en = 1'b1;
        tick();
        check("seq_start_level", fifo_level, 2);
        check("seq_start_underflow", underflow, 0);
        for (int p = 0; p < 7; p++) begin
            run_window();
            check($sformatf("seq_duty_l_p%0d", p), cnt_l, exp_l[p]);
            check($sformatf("seq_duty_r_p%0d", p), cnt_r, 255);
            if (p == 1) check("seq_level_p1", fifo_level, 1);
            if (p == 3) begin
                check("seq_level_p3", fifo_level, 0);
                check("seq_underflow_p3", underflow, 0);
            end
            if (p == 5) check("seq_underflow_p5", underflow, 1);
        end

        // Clear with no pop due, then clear colliding with a due pop
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check("clr_no_pop", underflow, 0);
        repeat (254) tick();
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check("clr_vs_set", underflow, 1);
        tick();
        check("underflow_sticky", underflow, 1);

        // Zero / one-count samples and refill interrupt
        cfg_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n          = 1'b1;
        cfg_repeat     = 8'd0;
        cfg_irq_thresh = 3'd1;
        push(16'h0100);
        push(16'h0100);
        push(16'h0100);
        check("irq_prefill_level", fifo_level, 3);
        check("irq_idle", irq, 0);
        cfg_en = 1'b1;
        tick();
        check("irq_start_level", fifo_level, 2);
        run_window();
        check("zero_duty_l", cnt_l, 0);
        check("one_duty_r", cnt_r, 1);
        check("irq_level_reached", fifo_level, 1);
        check("irq_not_yet", irq, 0);
        tick();
        check("irq_rise", irq, IRQ_ON);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
